// File: rtl/memory_arbiter.sv
// memory_arbiter: clocked front-end for the asynchronous main memory.
// Grants line requests from the icache (read-only) and the dcache (read/write)
// round-robin. It drives the memory's 4-phase enable/ack handshake and returns
// each result to the granted cache with a one-cycle ack pulse.
module memory_arbiter #(
   parameter int WIDTH   = 128,
   parameter int TIMEOUT = 1023
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ic_req,
   input  logic [31:0]      ic_addr,
   output logic             ic_ack,
   output logic [WIDTH-1:0] ic_rdata,
   input  logic             dc_req,
   input  logic             dc_rw,
   input  logic [31:0]      dc_addr,
   input  logic [WIDTH-1:0] dc_wdata,
   output logic             dc_ack,
   output logic [WIDTH-1:0] dc_rdata,
   output logic             mem_enable,
   output logic             mem_rw,
   output logic [31:0]      mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ack,
   output logic             err
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL, S_RSP} state_t;

   localparam logic GRANT_IC = 1'b0;
   localparam logic GRANT_DC = 1'b1;
   localparam logic [15:0] TIMER_MAX = 16'(TIMEOUT);

   state_t      state;
   logic        ack_meta;
   logic        ack_s;
   logic        last_grant;   // owner of the previous grant
   logic        grant;        // owner of the access in flight
   logic        pick_dc;
   logic [15:0] timer;
   logic [15:0] timer_inc;

   // Winner for the next grant: a lone requester wins; on a tie the port
   // that did not win last time goes next.
   always_comb begin
      pick_dc = dc_req;
      if (ic_req && dc_req)
         pick_dc = (last_grant == GRANT_IC);
   end

   // Saturate at TIMEOUT so a stuck handshake can never wrap the timer.
   assign timer_inc = (timer == TIMER_MAX) ? timer : timer + 16'd1;

   // Two-flop synchroniser for the memory's asynchronous ack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack_meta <= 1'b0;
         ack_s    <= 1'b0;
      end else begin
         ack_meta <= mem_ack;
         ack_s    <= ack_meta;
      end
   end

   // Handshake FSM with registered memory and client outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         last_grant <= GRANT_DC;   // so the first tie goes to the icache
         grant      <= GRANT_IC;
         timer      <= '0;
         err        <= 1'b0;
         mem_enable <= 1'b0;
         mem_rw     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         ic_ack     <= 1'b0;
         dc_ack     <= 1'b0;
         ic_rdata   <= '0;
         dc_rdata   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               timer <= '0;
               if (ic_req || dc_req) begin
                  grant      <= pick_dc;
                  last_grant <= pick_dc;
                  mem_addr   <= pick_dc ? dc_addr : ic_addr;
                  mem_rw     <= pick_dc ? dc_rw : 1'b1;   // icache only reads
                  if (pick_dc)
                     mem_wdata <= dc_wdata;
                  mem_enable <= 1'b1;
                  state      <= S_REQ;
               end
            end
            S_REQ: begin
               timer <= timer_inc;
               if (timer_inc == TIMER_MAX)
                  err <= 1'b1;
               if (ack_s) begin
                  // A write returns the line it just stored.
                  if (grant == GRANT_DC)
                     dc_rdata <= mem_rw ? mem_rdata : mem_wdata;
                  else
                     ic_rdata <= mem_rdata;
                  mem_enable <= 1'b0;
                  state      <= S_REL;
               end
            end
            S_REL: begin
               timer <= timer_inc;
               if (timer_inc == TIMER_MAX)
                  err <= 1'b1;
               if (!ack_s) begin
                  if (grant == GRANT_DC)
                     dc_ack <= 1'b1;
                  else
                     ic_ack <= 1'b1;
                  state <= S_RSP;
               end
            end
            S_RSP: begin
               ic_ack <= 1'b0;
               dc_ack <= 1'b0;
               timer  <= '0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: a behavioural 4-phase memory, a table of single
// requester accesses, and hand-written tie, reset, early-drop and timeout sequences.
module tb_memory_arbiter;

   localparam int WIDTH   = 128;
   localparam int TIMEOUT = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             ic_req, dc_req, dc_rw;
   logic [31:0]      ic_addr, dc_addr;
   logic [WIDTH-1:0] dc_wdata;
   logic             ic_ack, dc_ack;
   logic [WIDTH-1:0] ic_rdata, dc_rdata;
   logic             mem_enable, mem_rw;
   logic [31:0]      mem_addr;
   logic [WIDTH-1:0] mem_wdata, mem_rdata;
   logic             mem_ack;
   logic             err;

   memory_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rdata(ic_rdata),
      .dc_req(dc_req), .dc_rw(dc_rw), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .dc_ack(dc_ack), .dc_rdata(dc_rdata),
      .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int fails   = 0;
   int en_cnt  = 0;
   int ic_pulses = 0;
   int dc_pulses = 0;
   logic        last_rw;
   logic [31:0] last_addr;
   logic        ack_block = 1'b0;
   logic [WIDTH-1:0] mem [64];

   localparam logic [WIDTH-1:0] LINE4  = {4{32'hA000_0004}};
   localparam logic [WIDTH-1:0] LINE63 = {4{32'hA000_003F}};
   localparam logic [WIDTH-1:0] WDEAD  = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
   localparam logic [WIDTH-1:0] W1111  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [WIDTH-1:0] W6     = 128'hCAFE_F00D_0000_0000_FFFF_FFFF_1234_5678;

   typedef struct {
      bit               is_dc;
      bit               rw;
      logic [31:0]      addr;
      logic [WIDTH-1:0] wdata;
      logic [WIDTH-1:0] exp;
   } vec_t;
   vec_t vecs[8];

   // Behavioural asynchronous memory: ack 2 units after enable rises,
   // cleared 2 units after enable falls; ack_block holds the ack off.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      for (int i = 0; i < 64; i++) mem[i] = {4{32'hA000_0000 | i}};
      forever begin
         @(posedge mem_enable);
         #1;
         en_cnt++;
         last_rw   = mem_rw;
         last_addr = mem_addr;
         #1;
         wait (!ack_block || !mem_enable);
         if (mem_enable) begin
            if (!mem_rw) mem[mem_addr[9:4]] = mem_wdata;
            mem_rdata = mem_rw ? mem[mem_addr[9:4]] : mem_wdata;
            mem_ack = 1'b1;
            wait (!mem_enable);
            #2 mem_ack = 1'b0;
         end
      end
   end

   // Count cycles each client ack is high.
   always @(posedge clk) begin
      if (ic_ack) ic_pulses <= ic_pulses + 1;
      if (dc_ack) dc_pulses <= dc_pulses + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic void check(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endfunction

   task automatic wait_ack(output logic gi, output logic gd);
      gi = 1'b0;
      gd = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (ic_ack || dc_ack) begin
            gi = ic_ack;
            gd = dc_ack;
            return;
         end
      end
      vectors++;
      fails++;
      $display("FAIL ack_timeout: got no ack within 60 cycles");
   endtask

   task automatic run_vec(input vec_t v);
      int e0, ip0, dp0;
      logic gi, gd;
      @(negedge clk);
      e0 = en_cnt; ip0 = ic_pulses; dp0 = dc_pulses;
      if (v.is_dc) begin
         dc_req = 1'b1; dc_rw = v.rw; dc_addr = v.addr; dc_wdata = v.wdata;
      end else begin
         ic_req = 1'b1; ic_addr = v.addr;
      end
      wait_ack(gi, gd);
      ic_req = 1'b0;
      dc_req = 1'b0;
      check("ack_port", WIDTH'({gd, gi}), WIDTH'(v.is_dc ? 2'b10 : 2'b01));
      check("rdata", v.is_dc ? dc_rdata : ic_rdata, v.exp);
      check("mem_rw", WIDTH'(last_rw), WIDTH'(v.is_dc ? v.rw : 1'b1));
      check("mem_addr", WIDTH'(last_addr), WIDTH'(v.addr));
      repeat (4) @(posedge clk);
      #1;
      check("enable_pulses", WIDTH'(en_cnt - e0), WIDTH'(1));
      check("ack_pulses", WIDTH'({dc_pulses - dp0, ic_pulses - ip0}),
            WIDTH'({v.is_dc ? 32'd1 : 32'd0, v.is_dc ? 32'd0 : 32'd1}));
   endtask

   initial begin
      logic gi, gd;
      int e0, ip0, dp0;
      vec_t v6;
      reset = 1'b1;
      ic_req = 1'b0; dc_req = 1'b0; dc_rw = 1'b1;
      ic_addr = '0; dc_addr = '0; dc_wdata = '0;

      vecs[0] = '{1'b0, 1'b1, 32'h40,  '0,    LINE4};
      vecs[1] = '{1'b1, 1'b0, 32'h80,  WDEAD, WDEAD};
      vecs[2] = '{1'b1, 1'b1, 32'h80,  '0,    WDEAD};
      vecs[3] = '{1'b0, 1'b1, 32'h80,  '0,    WDEAD};
      vecs[4] = '{1'b1, 1'b0, 32'h100, W1111, W1111};
      vecs[5] = '{1'b1, 1'b1, 32'h40,  '0,    LINE4};
      vecs[6] = '{1'b0, 1'b1, 32'h3F0, '0,    LINE63};
      vecs[7] = '{1'b0, 1'b1, 32'h100, '0,    W1111};

      // reset state
      repeat (2) @(negedge clk);
      check("rst_acks", WIDTH'({ic_ack, dc_ack, err}), '0);
      check("rst_mem", WIDTH'({mem_enable, mem_rw, mem_addr}), '0);
      check("rst_wdata", mem_wdata, '0);
      check("rst_rdata", ic_rdata | dc_rdata, '0);
      reset = 1'b0;

      // single-requester table
      foreach (vecs[i]) run_vec(vecs[i]);

      // simultaneous requests after reset: IC first, then strict alternation
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      check("rst2_ic_rdata", ic_rdata, '0);
      @(negedge clk);
      ic_req = 1'b1; ic_addr = 32'h40;
      dc_req = 1'b1; dc_rw = 1'b1; dc_addr = 32'h80;
      wait_ack(gi, gd);
      ic_req = 1'b0;
      check("tie_first_ic", WIDTH'({gd, gi}), WIDTH'(2'b01));
      check("tie_first_data", ic_rdata, LINE4);
      wait_ack(gi, gd);
      check("tie_second_dc", WIDTH'({gd, gi}), WIDTH'(2'b10));
      check("tie_second_data", dc_rdata, WDEAD);
      ic_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_ack(gi, gd);
         check("alternate", WIDTH'({gd, gi}), WIDTH'((k % 2 == 0) ? 2'b01 : 2'b10));
      end
      ic_req = 1'b0;
      dc_req = 1'b0;

      // reset while the access is in S_REQ
      repeat (3) @(negedge clk);
      ip0 = ic_pulses; dp0 = dc_pulses;
      ic_req = 1'b1; ic_addr = 32'h40;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      #1 check("rst_mid_enable", WIDTH'(mem_enable), '0);
      ic_req = 1'b0;
      @(negedge clk);
      @(negedge clk) reset = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_mid_no_ack", WIDTH'({ic_pulses - ip0, dc_pulses - dp0}), '0);
      run_vec(vecs[0]);

      // dcache write with req dropped one cycle after the grant
      @(negedge clk);
      e0 = en_cnt; dp0 = dc_pulses;
      dc_req = 1'b1; dc_rw = 1'b0; dc_addr = 32'h200; dc_wdata = W6;
      @(posedge clk);
      @(posedge clk);
      #1 dc_req = 1'b0;
      wait_ack(gi, gd);
      check("early_drop_ack", WIDTH'({gd, gi}), WIDTH'(2'b10));
      repeat (15) @(posedge clk);
      #1;
      check("early_drop_enables", WIDTH'(en_cnt - e0), WIDTH'(1));
      check("early_drop_pulses", WIDTH'(dc_pulses - dp0), WIDTH'(1));
      v6 = '{1'b1, 1'b1, 32'h200, '0, W6};
      run_vec(v6);

      // stuck ack: err rises after TIMEOUT cycles and stays until reset
      @(negedge clk);
      ack_block = 1'b1;
      ic_req = 1'b1; ic_addr = 32'h80;
      @(posedge clk);
      repeat (TIMEOUT - 1) @(posedge clk);
      #1 check("err_before_timeout", WIDTH'(err), '0);
      @(posedge clk);
      #1 check("err_at_timeout", WIDTH'(err), WIDTH'(1));
      repeat (5) @(posedge clk);
      ack_block = 1'b0;
      wait_ack(gi, gd);
      ic_req = 1'b0;
      check("timeout_completes", WIDTH'({gd, gi}), WIDTH'(2'b01));
      check("timeout_data", ic_rdata, WDEAD);
      repeat (3) @(posedge clk);
      #1 check("err_sticky", WIDTH'(err), WIDTH'(1));
      @(negedge clk) reset = 1'b1;
      #1 check("err_cleared", WIDTH'(err), '0);
      @(negedge clk) reset = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
